// File: rtl/cpwr_accum_ctrl.sv
// cpwr_accum_ctrl: per-bin |x|^2 integrator between the FFT output and the
// spectrum BRAM. A four-register pipeline (input capture, squares, power with
// previous accumulator, result) combines each new power with the stored bin
// value in sum (saturating) or peak-hold mode. Bin/integration sequencing,
// first-pass load, sticky overflow and run completion are generated here.
module cpwr_accum_ctrl #(
    parameter int IN_WIDTH   = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int NBINS_LOG2 = 12,
    parameter int NINT_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clken,
    input  logic                       start,
    input  logic                       peak_mode,
    input  logic [NINT_WIDTH-1:0]      num_integrations,
    input  logic signed [IN_WIDTH-1:0] re_in,
    input  logic signed [IN_WIDTH-1:0] im_in,
    input  logic [ACC_WIDTH-1:0]       acc_in,
    output logic [NBINS_LOG2-1:0]      rd_addr,
    output logic [ACC_WIDTH-1:0]       acc_out,
    output logic [NBINS_LOG2-1:0]      acc_addr,
    output logic                       acc_valid,
    output logic                       is_greater,
    output logic                       overflow,
    output logic                       busy,
    output logic                       done
);

    localparam int PW = 2 * IN_WIDTH;
    localparam logic [NBINS_LOG2-1:0] BIN_LAST = '1;
    localparam logic [ACC_WIDTH-1:0]  ACC_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    // Run configuration and sequencing counters
    logic                  mode_peak;
    logic [NINT_WIDTH-1:0] nint;
    logic [NBINS_LOG2-1:0] bin_cnt;
    logic [NINT_WIDTH-1:0] int_cnt;

    logic start_ok;
    logic accept;
    logic bin_wrap;
    logic last_accept;

    // Pipeline stage 0: captured sample
    logic                       s0_valid;
    logic signed [IN_WIDTH-1:0] s0_re;
    logic signed [IN_WIDTH-1:0] s0_im;
    logic [NBINS_LOG2-1:0]      s0_bin;
    logic                       s0_first;
    logic                       s0_last;

    // Pipeline stage 1: squares
    logic                  s1_valid;
    logic [PW-1:0]         s1_sq_re;
    logic [PW-1:0]         s1_sq_im;
    logic [NBINS_LOG2-1:0] s1_bin;
    logic                  s1_first;
    logic                  s1_last;

    // Pipeline stage 2: power plus previous accumulator
    logic                  s2_valid;
    logic [PW-1:0]         s2_power;
    logic [ACC_WIDTH-1:0]  s2_acc;
    logic [NBINS_LOG2-1:0] s2_bin;
    logic                  s2_first;
    logic                  s2_last;

    // Stage 3 combine results
    logic signed [PW-1:0] re_ext;
    logic signed [PW-1:0] im_ext;
    logic [ACC_WIDTH-1:0] power_ext;
    logic [ACC_WIDTH:0]   sum_full;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 greater_next;
    logic                 sum_clamped;
    logic                 result_load;

    assign start_ok    = (state == IDLE) && start;
    assign accept      = (state == RUN) && clken;
    assign bin_wrap    = (bin_cnt == BIN_LAST);
    assign last_accept = accept && bin_wrap && (int_cnt == (nint - NINT_WIDTH'(1)));
    assign rd_addr     = bin_cnt;
    assign result_load = clken && s2_valid;

    // Sign-extend before multiplying so the square is formed at full width
    assign re_ext = PW'(s0_re);
    assign im_ext = PW'(s0_im);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: leave DRAIN once the final result has been presented
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)       state_next = RUN;
            RUN:     if (last_accept) state_next = DRAIN;
            DRAIN:   if (done)        state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // Latch run configuration on start and step the bin/integration counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_peak <= 1'b0;
            nint      <= NINT_WIDTH'(1);
            bin_cnt   <= '0;
            int_cnt   <= '0;
        end else if (start_ok) begin
            mode_peak <= peak_mode;
            nint      <= (num_integrations == '0) ? NINT_WIDTH'(1) : num_integrations;
            bin_cnt   <= '0;
            int_cnt   <= '0;
        end else if (accept) begin
            bin_cnt <= bin_cnt + NBINS_LOG2'(1);
            if (bin_wrap) begin
                int_cnt <= int_cnt + NINT_WIDTH'(1);
            end
        end
    end

    // Stage valid bits advance together on clken; only RUN injects new samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_valid <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (clken) begin
            s0_valid <= (state == RUN);
            s1_valid <= s0_valid;
            s2_valid <= s1_valid;
        end
    end

    // Pipeline datapath; contents are qualified by the valid bits so no reset
    always_ff @(posedge clk) begin
        if (clken) begin
            s0_re    <= re_in;
            s0_im    <= im_in;
            s0_bin   <= bin_cnt;
            s0_first <= (int_cnt == '0);
            s0_last  <= last_accept;

            s1_sq_re <= re_ext * re_ext;
            s1_sq_im <= im_ext * im_ext;
            s1_bin   <= s0_bin;
            s1_first <= s0_first;
            s1_last  <= s0_last;

            s2_power <= s1_sq_re + s1_sq_im;
            s2_acc   <= acc_in;
            s2_bin   <= s1_bin;
            s2_first <= s1_first;
            s2_last  <= s1_last;
        end
    end

    // Combine power with the stored value: first-pass load, saturating sum or peak
    always_comb begin
        power_ext    = ACC_WIDTH'(s2_power);
        sum_full     = {1'b0, s2_acc} + {1'b0, power_ext};
        sum_clamped  = 1'b0;
        acc_next     = power_ext;
        greater_next = (power_ext > s2_acc) && !s2_first;
        if (s2_first) begin
            acc_next = power_ext;
        end else if (mode_peak) begin
            acc_next = (power_ext > s2_acc) ? power_ext : s2_acc;
        end else if (sum_full[ACC_WIDTH]) begin
            acc_next    = ACC_MAX;
            sum_clamped = 1'b1;
        end else begin
            acc_next = sum_full[ACC_WIDTH-1:0];
        end
    end

    // Result register; strobes are rebuilt every clk so they stay one clk wide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_out    <= '0;
            acc_addr   <= '0;
            acc_valid  <= 1'b0;
            is_greater <= 1'b0;
            done       <= 1'b0;
        end else begin
            acc_valid <= result_load;
            done      <= result_load && s2_last;
            if (result_load) begin
                acc_out    <= acc_next;
                acc_addr   <= s2_bin;
                is_greater <= greater_next;
            end
        end
    end

    // Sticky saturation flag, cleared when a new run starts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (start_ok) begin
            overflow <= 1'b0;
        end else if (result_load && sum_clamped) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpwr_accum_ctrl.sv
// tb_cpwr_accum_ctrl: directed checks of the power integrator with four bins
// and a 32-bit accumulator, using a two-clken-latency BRAM model for acc_in.
module tb_cpwr_accum_ctrl;

    logic               clk;
    logic               rst;
    logic               clken;
    logic               start;
    logic               peak_mode;
    logic [9:0]         num_integrations;
    logic signed [15:0] re_in;
    logic signed [15:0] im_in;
    logic [31:0]        acc_in;
    logic [1:0]         rd_addr;
    logic [31:0]        acc_out;
    logic [1:0]         acc_addr;
    logic               acc_valid;
    logic               is_greater;
    logic               overflow;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;

    logic signed [15:0] tab_re [16];
    logic signed [15:0] tab_im [16];

    logic        use_mem;
    logic [31:0] acc_force;
    logic [31:0] mem [4];
    logic [1:0]  d1;
    logic [1:0]  d2;

    logic [31:0] q_out  [$];
    logic [1:0]  q_addr [$];
    logic        q_gt   [$];
    logic        q_ovf  [$];
    int          done_cnt    = 0;
    int          done_orphan = 0;

    cpwr_accum_ctrl #(
        .IN_WIDTH   (16),
        .ACC_WIDTH  (32),
        .NBINS_LOG2 (2),
        .NINT_WIDTH (10)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .clken            (clken),
        .start            (start),
        .peak_mode        (peak_mode),
        .num_integrations (num_integrations),
        .re_in            (re_in),
        .im_in            (im_in),
        .acc_in           (acc_in),
        .rd_addr          (rd_addr),
        .acc_out          (acc_out),
        .acc_addr         (acc_addr),
        .acc_valid        (acc_valid),
        .is_greater       (is_greater),
        .overflow         (overflow),
        .busy             (busy),
        .done             (done)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Spectrum BRAM model: written by acc_valid, read two clken edges after rd_addr
    always @(posedge clk) begin
        if (acc_valid) mem[acc_addr] <= acc_out;
        if (clken) begin
            d1 <= rd_addr;
            d2 <= d1;
        end
    end

    assign acc_in = use_mem ? mem[d2] : acc_force;

    // Result monitor sampled mid-cycle
    always @(negedge clk) begin
        if (acc_valid) begin
            q_out.push_back(acc_out);
            q_addr.push_back(acc_addr);
            q_gt.push_back(is_greater);
            q_ovf.push_back(overflow);
        end
        if (done) begin
            done_cnt++;
            if (!acc_valid) done_orphan++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tab(input int k, input int re, input int im);
        tab_re[k] = 16'(re);
        tab_im[k] = 16'(im);
    endtask

    task automatic do_start(input logic mode, input logic [9:0] n);
        clken            = 1'b0;
        start            = 1'b1;
        peak_mode        = mode;
        num_integrations = n;
        step();
        start            = 1'b0;
        peak_mode        = ~mode;
        num_integrations = 10'd7;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_busy: got %0b expected 1", busy);
        end
    endtask

    task automatic feed(input int nsamp, input bit gaps);
        int  guard;
        bit  accepted;
        for (int k = 0; k < nsamp; k++) begin
            re_in    = tab_re[k];
            im_in    = tab_im[k];
            accepted = 1'b0;
            guard    = 0;
            while (!accepted) begin
                clken = (!gaps || guard >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
                if (clken) begin
                    checks++;
                    if (rd_addr !== 2'(k % 4)) begin
                        errors++;
                        $display("[TB] FAIL rd_addr[%0d]: got %0d expected %0d", k, rd_addr, k % 4);
                    end
                    accepted = 1'b1;
                end
                step();
                guard++;
            end
        end
    endtask

    task automatic drain(input bit gaps);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            clken = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL drain_done: got no done expected done within 40 clk");
        end
        clken = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_done: got busy=%0b done=%0b expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
        step();
        checks++;
        if ({acc_out, acc_addr, acc_valid, is_greater, overflow, busy, done, rd_addr} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got out=%0h addr=%0d v=%0b gt=%0b ovf=%0b busy=%0b done=%0b rd=%0d expected all 0",
                     acc_out, acc_addr, acc_valid, is_greater, overflow, busy, done, rd_addr);
        end
        rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || acc_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got busy=%0b valid=%0b expected 0 0", busy, acc_valid);
        end
    endtask

    task automatic test_basic();
        use_mem = 1'b1;
        do_start(1'b0, 10'd1);
        for (int i = 0; i < 8; i++) begin
            re_in = 16'sd3;
            im_in = -16'sd4;
            clken = 1'b1;
            if (i < 4) begin
                checks++;
                if (rd_addr !== 2'(i)) begin
                    errors++;
                    $display("[TB] FAIL basic_rd_addr[%0d]: got %0d expected %0d", i, rd_addr, i);
                end
            end
            step();
            checks++;
            if (acc_valid !== 1'(i >= 3 && i <= 6)) begin
                errors++;
                $display("[TB] FAIL basic_valid[%0d]: got %0b expected %0b", i, acc_valid, (i >= 3 && i <= 6));
            end
            if (i >= 3 && i <= 6) begin
                checks++;
                if (acc_addr !== 2'(i - 3) || acc_out !== 32'd25 || is_greater !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL basic_result[%0d]: got addr=%0d out=%0d gt=%0b expected addr=%0d out=25 gt=0",
                             i, acc_addr, acc_out, is_greater, i - 3);
                end
            end
            checks++;
            if (done !== 1'(i == 6) || busy !== 1'(i <= 6)) begin
                errors++;
                $display("[TB] FAIL basic_status[%0d]: got done=%0b busy=%0b expected done=%0b busy=%0b",
                         i, done, busy, (i == 6), (i <= 6));
            end
        end
        clken = 1'b0;
    endtask

    task automatic test_sum_integration();
        int base;
        int dbase;
        int obase;
        base  = q_out.size();
        dbase = done_cnt;
        obase = done_orphan;
        use_mem = 1'b1;
        for (int k = 0; k < 12; k++) set_tab(k, 1, 1);
        do_start(1'b0, 10'd3);
        start            = 1'b1;
        peak_mode        = 1'b1;
        num_integrations = 10'd1;
        clken            = 1'b0;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rd_addr !== 2'd0) begin
            errors++;
            $display("[TB] FAIL sum_start_ignored: got busy=%0b rd=%0d expected 1 0", busy, rd_addr);
        end
        feed(12, 1'b1);
        drain(1'b1);
        checks++;
        if (q_out.size() - base !== 12) begin
            errors++;
            $display("[TB] FAIL sum_count: got %0d expected 12", q_out.size() - base);
        end
        for (int r = 0; r < 12 && base + r < q_out.size(); r++) begin
            checks++;
            if (q_out[base+r] !== 32'(2 * (r / 4 + 1)) || q_addr[base+r] !== 2'(r % 4) || q_gt[base+r] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sum_result[%0d]: got out=%0d addr=%0d gt=%0b expected out=%0d addr=%0d gt=0",
                         r, q_out[base+r], q_addr[base+r], q_gt[base+r], 2 * (r / 4 + 1), r % 4);
            end
        end
        checks++;
        if (done_cnt - dbase !== 1 || done_orphan - obase !== 0 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sum_done: got dones=%0d orphan=%0d ovf=%0b expected 1 0 0",
                     done_cnt - dbase, done_orphan - obase, overflow);
        end
    endtask

    task automatic test_peak();
        int          base;
        logic [31:0] exp_out [8];
        logic        exp_gt  [8];
        base = q_out.size();
        use_mem = 1'b1;
        for (int k = 0; k < 4; k++) set_tab(k, 6, 8);
        set_tab(4, 5, 5);
        set_tab(5, 10, 10);
        set_tab(6, 8, 6);
        set_tab(7, 10, 1);
        exp_out = '{32'd100, 32'd100, 32'd100, 32'd100, 32'd100, 32'd200, 32'd100, 32'd101};
        exp_gt  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_start(1'b1, 10'd2);
        feed(8, 1'b0);
        drain(1'b0);
        checks++;
        if (q_out.size() - base !== 8) begin
            errors++;
            $display("[TB] FAIL peak_count: got %0d expected 8", q_out.size() - base);
        end
        for (int r = 0; r < 8 && base + r < q_out.size(); r++) begin
            checks++;
            if (q_out[base+r] !== exp_out[r] || q_gt[base+r] !== exp_gt[r] || q_addr[base+r] !== 2'(r % 4)) begin
                errors++;
                $display("[TB] FAIL peak_result[%0d]: got out=%0d gt=%0b addr=%0d expected out=%0d gt=%0b addr=%0d",
                         r, q_out[base+r], q_gt[base+r], q_addr[base+r], exp_out[r], exp_gt[r], r % 4);
            end
        end
    endtask

    task automatic test_overflow();
        int base;
        base = q_out.size();
        use_mem   = 1'b0;
        acc_force = 32'hFFFF_FFF0;
        for (int k = 0; k < 8; k++) set_tab(k, 4, 4);
        do_start(1'b0, 10'd2);
        feed(8, 1'b0);
        drain(1'b0);
        checks++;
        if (q_out.size() - base !== 8) begin
            errors++;
            $display("[TB] FAIL ovf_count: got %0d expected 8", q_out.size() - base);
        end
        for (int r = 0; r < 8 && base + r < q_out.size(); r++) begin
            checks++;
            if (q_out[base+r] !== ((r < 4) ? 32'h20 : 32'hFFFF_FFFF) || q_ovf[base+r] !== 1'(r >= 4) || q_gt[base+r] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ovf_result[%0d]: got out=%0h ovf=%0b gt=%0b expected out=%0h ovf=%0b gt=0",
                         r, q_out[base+r], q_ovf[base+r], q_gt[base+r], (r < 4) ? 32'h20 : 32'hFFFF_FFFF, (r >= 4));
            end
        end
        step();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sticky: got %0b expected 1", overflow);
        end
        use_mem = 1'b1;
    endtask

    task automatic test_extreme();
        int          base;
        logic [31:0] exp_out [4];
        base = q_out.size();
        use_mem = 1'b1;
        set_tab(0, -32768, -32768);
        set_tab(1, -32768, 0);
        set_tab(2, 32767, -32768);
        set_tab(3, 0, 0);
        exp_out = '{32'h8000_0000, 32'h4000_0000, 32'h7FFF_0001, 32'h0};
        do_start(1'b0, 10'd1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_clear_on_start: got %0b expected 0", overflow);
        end
        feed(4, 1'b0);
        drain(1'b0);
        for (int r = 0; r < 4 && base + r < q_out.size(); r++) begin
            checks++;
            if (q_out[base+r] !== exp_out[r]) begin
                errors++;
                $display("[TB] FAIL extreme_result[%0d]: got %0h expected %0h", r, q_out[base+r], exp_out[r]);
            end
        end
        checks++;
        if (q_out.size() - base !== 4 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL extreme_count: got n=%0d ovf=%0b expected 4 0", q_out.size() - base, overflow);
        end
    endtask

    task automatic test_reset_midrun();
        int base;
        int dbase;
        use_mem = 1'b1;
        do_start(1'b0, 10'd3);
        for (int i = 0; i < 10; i++) begin
            re_in = 16'sd7;
            im_in = 16'sd7;
            clken = 1'($urandom_range(0, 1));
            step();
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrun_busy: got %0b expected 1", busy);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({acc_out, acc_addr, acc_valid, is_greater, overflow, busy, done, rd_addr} !== '0) begin
            errors++;
            $display("[TB] FAIL midrun_reset: got out=%0h addr=%0d v=%0b gt=%0b ovf=%0b busy=%0b done=%0b rd=%0d expected all 0",
                     acc_out, acc_addr, acc_valid, is_greater, overflow, busy, done, rd_addr);
        end
        for (int i = 0; i < 2; i++) begin
            clken = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b1;
        clken = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || acc_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrun_idle: got busy=%0b valid=%0b expected 0 0", busy, acc_valid);
        end
        base  = q_out.size();
        dbase = done_cnt;
        for (int k = 0; k < 4; k++) set_tab(k, 3, -4);
        do_start(1'b0, 10'd0);
        feed(4, 1'b1);
        drain(1'b1);
        checks++;
        if (q_out.size() - base !== 4 || done_cnt - dbase !== 1) begin
            errors++;
            $display("[TB] FAIL nint0_count: got n=%0d dones=%0d expected 4 1", q_out.size() - base, done_cnt - dbase);
        end
        for (int r = 0; r < 4 && base + r < q_out.size(); r++) begin
            checks++;
            if (q_out[base+r] !== 32'd25 || q_addr[base+r] !== 2'(r)) begin
                errors++;
                $display("[TB] FAIL nint0_result[%0d]: got out=%0d addr=%0d expected 25 %0d",
                         r, q_out[base+r], q_addr[base+r], r);
            end
        end
    endtask

    // Directed test sequence
    initial begin
        clken            = 1'b0;
        start            = 1'b0;
        peak_mode        = 1'b0;
        num_integrations = 10'd0;
        re_in            = 16'sd0;
        im_in            = 16'sd0;
        use_mem          = 1'b1;
        acc_force        = 32'd0;
        test_reset();
        test_basic();
        test_sum_integration();
        test_peak();
        test_overflow();
        test_extreme();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
